// File: rtl/arith_pkg.sv
// Shared encodings for arith_unit: opcodes and FSM state type.
// ARITH_UNIT_MUL_EN adds the CALC state used by the multiply engine.
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

`ifdef ARITH_UNIT_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_e;
`endif

endpackage

// File: rtl/arith_unit_addsub.sv
// Combinational ripple-carry adder/subtractor: sub_i=1 computes a + ~b + 1.
// Carry out of the MSB doubles as the "a >= b" flag when subtracting.
module addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] b_eff;

    always_comb begin
        b_eff = sub_i ? ~b_i : b_i;
        c     = '0;
        c[0]  = sub_i;
        sum_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = a_i[i] ^ b_eff[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_eff[i]) | (c[i] & (a_i[i] ^ b_eff[i]));
        end
        carry_o = c[WIDTH];
        // Signed overflow: carry into the sign bit differs from carry out of it.
        ovf_o   = c[WIDTH] ^ c[WIDTH-1];
    end

endmodule

// File: rtl/arith_unit.sv
// Handshaked ADD/SUB/MUL unit: IDLE -> (CALC) -> DONE, one operation in flight.
// Define ARITH_UNIT_MUL_EN to build the shift-add multiplier; otherwise MUL is reserved.
module arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_carry,
    output logic                 out_ovf,
    output logic                 out_zero,
    output logic                 out_err
);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;
    logic                 err_q, err_d;

    logic [WIDTH-1:0]     as_sum;
    logic                 as_carry;
    logic                 as_ovf;

`ifdef ARITH_UNIT_MUL_EN
    localparam int MUL_CYCLES = WIDTH;
    localparam int CNT_W      = $clog2(MUL_CYCLES);

    logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, acc_sum;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

    addsub_core #(.WIDTH(WIDTH)) u_addsub (
        .a_i    (in_a),
        .b_i    (in_b),
        .sub_i  (in_op == OP_SUB),
        .sum_o  (as_sum),
        .carry_o(as_carry),
        .ovf_o  (as_ovf)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        err_d    = err_q;
`ifdef ARITH_UNIT_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DONE;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    case (in_op)
                        OP_ADD, OP_SUB: begin
                            result_d = {{WIDTH{1'b0}}, as_sum};
                            carry_d  = as_carry;
                            ovf_d    = as_ovf;
                            zero_d   = (as_sum == '0);
                        end
`ifdef ARITH_UNIT_MUL_EN
                        OP_MUL: begin
                            state_d  = CALC;
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, in_a};
                            mplier_d = in_b;
                            cnt_d    = '0;
                        end
`endif
                        default: begin
                            result_d = '0;
                            zero_d   = 1'b1;
                            err_d    = 1'b1;
                        end
                    endcase
                end
            end
`ifdef ARITH_UNIT_MUL_EN
            // One partial product per cycle, LSB of the multiplier first.
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                    state_d  = DONE;
                    result_d = acc_sum;
                    zero_d   = (acc_sum == '0);
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

`ifdef ARITH_UNIT_MUL_EN
    // Multiplier working registers are only meaningful while in CALC.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        cnt_q    <= cnt_d;
    end
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;
    assign out_carry  = carry_q;
    assign out_ovf    = ovf_q;
    assign out_zero   = zero_q;
    assign out_err    = err_q;

endmodule

// File: doc/arith_unit.md
ARITH_UNIT -- requirements
Module: arith_unit

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits, legal range 2..32.
REQ-002 Parameter MUL_CYCLES, fixed equal to WIDTH and not overridable: iteration count of the multiply engine.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  unit can accept a new operation.
REQ-007 in_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 reserved.
REQ-008 in_a, in_b  input  WIDTH  unsigned operands; two's complement for overflow purposes.
REQ-009 out_valid  output  1  result presented.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_result  output  2*WIDTH  result; ADD/SUB occupy bits [WIDTH-1:0], upper bits 0.
REQ-012 out_carry, out_ovf, out_zero, out_err  output  1 each  status flags.

Function
REQ-013 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept occurs on a cycle with in_valid=1 and in_ready=1; in_op, in_a and in_b SHALL be captured on that edge.
REQ-015 ADD/SUB/reserved: IDLE->DONE on accept; out_valid SHALL be 1 on the first cycle after accept (latency 1).
REQ-016 MUL: IDLE->CALC on accept; one shift-add step per cycle for WIDTH cycles; CALC->DONE after the last step; out_valid SHALL be 1 exactly WIDTH+1 cycles after accept.
REQ-017 DONE->IDLE on the cycle out_valid=1 and out_ready=1; while out_ready=0, out_result and all flags SHALL hold stable.
REQ-018 There is no same-cycle DONE->accept bypass; back-to-back ADD operations therefore complete at most one every 2 cycles.
REQ-019 ADD: result = (a+b) mod 2^WIDTH; out_carry = carry out of the MSB; out_ovf = signed overflow.
REQ-020 SUB: result = a + ~b + 1 mod 2^WIDTH; out_carry = 1 iff a >= b (unsigned); out_ovf = signed overflow.
REQ-021 MUL: result = unsigned a*b as a full 2*WIDTH-bit value; out_carry=0; out_ovf=0.
REQ-022 out_zero SHALL be 1 iff out_result == 0, for every op.
REQ-023 Reserved op: out_err=1, out_result=0, out_zero=1, other flags 0.
REQ-024 Inputs presented while in_ready=0 SHALL be ignored, with no effect on state.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, with out_valid=0, out_result=0 and all flags 0, independent of clk.
REQ-026 Reset asserted mid-CALC or mid-DONE SHALL discard the operation; no result is emitted after release.
REQ-027 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro ARITH_UNIT_MUL_EN: when defined, MUL behaves as specified and the CALC state and multiply datapath are present.
REQ-029 Without ARITH_UNIT_MUL_EN, op 10 SHALL be treated as reserved (REQ-023, latency 1), and no multiply logic or CALC state is synthesised.

Structure
REQ-030 Package arith_pkg SHALL hold the op encoding constants (OP_ADD, OP_SUB, OP_MUL, OP_RSV) and the FSM state typedef.
REQ-031 Sub-module addsub_core (WIDTH-parametrised combinational ripple add/sub with a sub control input, producing sum, carry and ovf) SHALL implement REQ-019/020.
REQ-032 The same addsub_core instance SHALL NOT be reused for the MUL accumulator; the multiply engine lives in arith_unit.

Verification (WIDTH=4)
REQ-033 ADD 7+9 -> result 0x00, carry=1, ovf=0, zero=1, out_valid one cycle after accept.
REQ-034 SUB 3-5 -> 0x0E, carry=0, ovf=0; SUB 8-1 -> 0x07, carry=1, ovf=1.
REQ-035 MUL 15*15 -> 0xE1, out_valid exactly 5 cycles after accept, in_ready=0 throughout; without the macro -> err=1 after 1 cycle.
REQ-036 out_ready held 0 for 3 cycles after out_valid -> result and flags unchanged, in_ready=0, new in_valid ignored.
REQ-037 rst_n pulsed low 2 cycles into a MUL -> outputs 0 immediately, no out_valid after release, in_ready=1 on the next cycle.
REQ-038 in_op=11 with a=5, b=3 -> err=1, result 0, zero=1.
